// File: rtl/nqueen_stack_solver.sv
// ---------------------------------------------------------------------------
// nqueen_stack_solver
//
// Backtracking N-queens solver. The FSM and the column stack live together in
// this block. The stack stk[r] holds the queen column placed in row r, and
// r_row is the current stack depth. The search either stops at the first
// solution or enumerates every solution (find_all). Each solution leaves the
// block as a valid/ready stream with one beat per row.
//
// Parameters
//   N      board size, 1..16
//   CNT_W  width of the saturating solution counter
//
// Ports
//   clk         rising-edge clock
//   user_reset  synchronous active-high reset
//   start       begin a solve (only looked at while idle)
//   find_all    0 = stop after the first solution, 1 = enumerate all
//   ready       high while idle
//   busy        high in every non-idle state
//   done        1-cycle pulse: finished with at least one solution
//   no_answer   1-cycle pulse: finished with zero solutions
//   sol_valid   solution beat valid
//   sol_ready   consumer accepts the beat
//   sol_row     row index of the beat
//   sol_col     queen column in that row
//   sol_last    beat is the final row
//   sol_count   solutions emitted since the last start
// ---------------------------------------------------------------------------
module nqueen_stack_solver #(
    parameter  int N     = 8,
    parameter  int CNT_W = 16,
    localparam int POS_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             user_reset,
    input  logic             start,
    input  logic             find_all,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             no_answer,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic [POS_W-1:0] sol_row,
    output logic [POS_W-1:0] sol_col,
    output logic             sol_last,
    output logic [CNT_W-1:0] sol_count
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT      = 4'd1,
        S_TEST      = 4'd2,
        S_CHECK     = 4'd3,
        S_PLACE     = 4'd4,
        S_BACKTRACK = 4'd5,
        S_EMIT      = 4'd6,
        S_DONE      = 4'd7,
        S_NO_ANSWER = 4'd8
    } state_t;

    localparam logic [POS_W-1:0] P_N    = POS_W'(N);
    localparam logic [POS_W-1:0] P_LAST = POS_W'(N - 1);
    localparam logic [CNT_W-1:0] P_CMAX = {CNT_W{1'b1}};

    // Registered state
    state_t             r_state;
    logic [POS_W-1:0]   r_row;
    logic [POS_W-1:0]   r_col;
    logic [POS_W-1:0]   r_k;
    logic [POS_W-1:0]   r_i;
    logic [CNT_W-1:0]   r_sol_count;
    logic               r_find_all;
    logic [POS_W-1:0]   r_stk [N];

    // Next-state values
    state_t             w_state_next;
    logic [POS_W-1:0]   w_row_next;
    logic [POS_W-1:0]   w_col_next;
    logic [POS_W-1:0]   w_k_next;
    logic [POS_W-1:0]   w_i_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_find_all_next;
    logic               w_push;

    // Stack read ports
    logic [POS_W-1:0]   w_stk_k;    // queen being compared in CHECK
    logic [POS_W-1:0]   w_stk_top;  // queen of row r_row-1, restored on backtrack
    logic [POS_W-1:0]   w_stk_i;    // queen of the row being emitted

    logic [POS_W-1:0]   w_diff;
    logic [POS_W-1:0]   w_dist;
    logic               w_conflict;

    // The stack is small (at most 16 entries), so it is read through plain
    // index-compare muxes. An index outside 0..N-1 reads as zero.
    always_comb begin
        w_stk_k   = '0;
        w_stk_top = '0;
        w_stk_i   = '0;
        for (int j = 0; j < N; j++) begin
            if (r_k == POS_W'(j))
                w_stk_k = r_stk[j];
            if (r_row == POS_W'(j + 1))
                w_stk_top = r_stk[j];
            if (r_i == POS_W'(j))
                w_stk_i = r_stk[j];
        end
    end

    // Absolute column distance is taken without wrap. Because k < row, the
    // row distance row-k is always positive.
    always_comb begin
        w_diff     = (w_stk_k > r_col) ? (w_stk_k - r_col) : (r_col - w_stk_k);
        w_dist     = r_row - r_k;
        w_conflict = (w_stk_k == r_col) || (w_diff == w_dist);
    end

    // Next-state and datapath control
    always_comb begin
        w_state_next    = r_state;
        w_row_next      = r_row;
        w_col_next      = r_col;
        w_k_next        = r_k;
        w_i_next        = r_i;
        w_cnt_next      = r_sol_count;
        w_find_all_next = r_find_all;
        w_push          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_find_all_next = find_all;
                    w_state_next    = S_INIT;
                end
            end

            S_INIT: begin
                w_row_next   = '0;
                w_col_next   = '0;
                w_cnt_next   = '0;
                w_state_next = S_TEST;
            end

            S_TEST: begin
                if (r_row == P_N) begin
                    w_i_next     = '0;
                    w_state_next = S_EMIT;
                end else if (r_col == P_N) begin
                    w_state_next = S_BACKTRACK;
                end else if (r_row == '0) begin
                    w_state_next = S_PLACE;
                end else begin
                    w_k_next     = r_row - 1'b1;
                    w_state_next = S_CHECK;
                end
            end

            // Scan the placed queens from the nearest row down to row 0, one
            // queen per cycle. The first conflict found moves to the next column.
            S_CHECK: begin
                if (w_conflict) begin
                    w_col_next   = r_col + 1'b1;
                    w_state_next = S_TEST;
                end else if (r_k == '0) begin
                    w_state_next = S_PLACE;
                end else begin
                    w_k_next = r_k - 1'b1;
                end
            end

            S_PLACE: begin
                w_push       = 1'b1;
                w_row_next   = r_row + 1'b1;
                w_col_next   = '0;
                w_state_next = S_TEST;
            end

            S_BACKTRACK: begin
                if (r_row == '0) begin
                    w_state_next = (r_sol_count == '0) ? S_NO_ANSWER : S_DONE;
                end else begin
                    w_col_next   = w_stk_top + 1'b1;
                    w_row_next   = r_row - 1'b1;
                    w_state_next = S_TEST;
                end
            end

            // The search holds still here until every beat has been accepted.
            // In find-all mode it then backtracks from row N, which moves the
            // last queen one column on.
            S_EMIT: begin
                if (sol_ready) begin
                    w_i_next = r_i + 1'b1;
                    if (r_i == P_LAST) begin
                        if (r_sol_count != P_CMAX)
                            w_cnt_next = r_sol_count + 1'b1;
                        w_state_next = r_find_all ? S_BACKTRACK : S_DONE;
                    end
                end
            end

            S_DONE:      w_state_next = S_IDLE;
            S_NO_ANSWER: w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (user_reset) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_k         <= '0;
            r_i         <= '0;
            r_sol_count <= '0;
            r_find_all  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_row       <= w_row_next;
            r_col       <= w_col_next;
            r_k         <= w_k_next;
            r_i         <= w_i_next;
            r_sol_count <= w_cnt_next;
            r_find_all  <= w_find_all_next;
        end
    end

    // Stack contents are only meaningful below r_row, so they are never
    // cleared.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (w_push && (r_row == POS_W'(j)))
                r_stk[j] <= r_col;
        end
    end

    // Moore outputs. The pulses and sol_valid are also forced low while reset
    // is asserted, so a reset arriving mid-stream cannot leave a stale beat
    // or pulse visible.
    assign ready     = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE)      && !user_reset;
    assign no_answer = (r_state == S_NO_ANSWER) && !user_reset;
    assign sol_valid = (r_state == S_EMIT)      && !user_reset;
    assign sol_row   = r_i;
    assign sol_col   = w_stk_i;
    assign sol_last  = (r_i == P_LAST);
    assign sol_count = r_sol_count;

endmodule

// File: tb/tb_nqueen_stack_solver.sv
// ---------------------------------------------------------------------------
// tb_nqueen_stack_solver
//
// Directed bench with one solver instance per board size under test:
//   u8a  N=8  first-solution runs and mid-search / mid-stream resets
//   u8b  N=8  full enumeration (runs alongside the other scenarios)
//   u4   N=4  full enumeration with sol_ready toggling every cycle
//   u3   N=3  and u2 N=2: no solution exists
//   u1   N=1  trivial board
// Expected columns are hand-derived lexicographic solutions.
// ---------------------------------------------------------------------------
module tb_nqueen_stack_solver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- u8a: N=8 ----------------
    logic        a_rst = 1'b1, a_start = 1'b0, a_fa = 1'b0, a_srdy = 1'b1;
    logic        a_ready, a_busy, a_done, a_na, a_valid, a_last;
    logic [3:0]  a_row, a_col;
    logic [15:0] a_cnt;

    nqueen_stack_solver #(.N(8)) u8a (
        .clk(clk), .user_reset(a_rst), .start(a_start), .find_all(a_fa),
        .ready(a_ready), .busy(a_busy), .done(a_done), .no_answer(a_na),
        .sol_valid(a_valid), .sol_ready(a_srdy), .sol_row(a_row),
        .sol_col(a_col), .sol_last(a_last), .sol_count(a_cnt)
    );

    // ---------------- u8b: N=8 find-all ----------------
    logic        b_rst = 1'b1, b_start = 1'b0, b_fa = 1'b1, b_srdy = 1'b1;
    logic        b_ready, b_busy, b_done, b_na, b_valid, b_last;
    logic [3:0]  b_row, b_col;
    logic [15:0] b_cnt;

    nqueen_stack_solver #(.N(8)) u8b (
        .clk(clk), .user_reset(b_rst), .start(b_start), .find_all(b_fa),
        .ready(b_ready), .busy(b_busy), .done(b_done), .no_answer(b_na),
        .sol_valid(b_valid), .sol_ready(b_srdy), .sol_row(b_row),
        .sol_col(b_col), .sol_last(b_last), .sol_count(b_cnt)
    );

    // ---------------- shared controls for the small boards ----------------
    logic m_rst = 1'b1;

    // u4: N=4
    logic        q_start = 1'b0, q_fa = 1'b1, q_srdy = 1'b0;
    logic        q_ready, q_busy, q_done, q_na, q_valid, q_last;
    logic [2:0]  q_row, q_col;
    logic [15:0] q_cnt;

    nqueen_stack_solver #(.N(4)) u4 (
        .clk(clk), .user_reset(m_rst), .start(q_start), .find_all(q_fa),
        .ready(q_ready), .busy(q_busy), .done(q_done), .no_answer(q_na),
        .sol_valid(q_valid), .sol_ready(q_srdy), .sol_row(q_row),
        .sol_col(q_col), .sol_last(q_last), .sol_count(q_cnt)
    );

    // u3 / u2 share start and find_all
    logic        t_start = 1'b0, t_fa = 1'b1, t_srdy = 1'b1;
    logic        t3_ready, t3_busy, t3_done, t3_na, t3_valid, t3_last;
    logic [1:0]  t3_row, t3_col;
    logic [15:0] t3_cnt;
    logic        t2_ready, t2_busy, t2_done, t2_na, t2_valid, t2_last;
    logic [1:0]  t2_row, t2_col;
    logic [15:0] t2_cnt;

    nqueen_stack_solver #(.N(3)) u3 (
        .clk(clk), .user_reset(m_rst), .start(t_start), .find_all(t_fa),
        .ready(t3_ready), .busy(t3_busy), .done(t3_done), .no_answer(t3_na),
        .sol_valid(t3_valid), .sol_ready(t_srdy), .sol_row(t3_row),
        .sol_col(t3_col), .sol_last(t3_last), .sol_count(t3_cnt)
    );

    nqueen_stack_solver #(.N(2)) u2 (
        .clk(clk), .user_reset(m_rst), .start(t_start), .find_all(t_fa),
        .ready(t2_ready), .busy(t2_busy), .done(t2_done), .no_answer(t2_na),
        .sol_valid(t2_valid), .sol_ready(t_srdy), .sol_row(t2_row),
        .sol_col(t2_col), .sol_last(t2_last), .sol_count(t2_cnt)
    );

    // u1: N=1
    logic        o_start = 1'b0, o_fa = 1'b0, o_srdy = 1'b1;
    logic        o_ready, o_busy, o_done, o_na, o_valid, o_last;
    logic [0:0]  o_row, o_col;
    logic [15:0] o_cnt;

    nqueen_stack_solver #(.N(1)) u1 (
        .clk(clk), .user_reset(m_rst), .start(o_start), .find_all(o_fa),
        .ready(o_ready), .busy(o_busy), .done(o_done), .no_answer(o_na),
        .sol_valid(o_valid), .sol_ready(o_srdy), .sol_row(o_row),
        .sol_col(o_col), .sol_last(o_last), .sol_count(o_cnt)
    );

    // ---------------------------------------------------------------------
    // N=8 first solution on u8a
    // ---------------------------------------------------------------------
    task automatic run_first8(input string tag);
        int exp_col[8] = '{0, 4, 7, 5, 2, 6, 1, 3};
        int beats = 0;
        bit got_done = 1'b0;
        a_fa = 1'b0; a_srdy = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        for (int c = 0; c < 20000 && !got_done; c++) begin
            @(posedge clk); #1;
            if (a_valid) begin
                if (beats < 8) begin
                    check_eq({tag, "_row"},  int'(a_row),  beats);
                    check_eq({tag, "_col"},  int'(a_col),  exp_col[beats]);
                    check_eq({tag, "_last"}, int'(a_last), (beats == 7) ? 1 : 0);
                    $display("%s beat row=%0d col=%0d last=%0d", tag, a_row, a_col, a_last);
                end else begin
                    check_eq({tag, "_beat_count"}, beats + 1, 8);
                end
                beats++;
            end
            if (a_done) got_done = 1'b1;
        end
        check_eq({tag, "_done_seen"}, int'(got_done), 1);
        check_eq({tag, "_beats"},     beats,          8);
        check_eq({tag, "_count"},     int'(a_cnt),    1);
        @(posedge clk); #1;
        check_eq({tag, "_done_width"}, int'(a_done),  0);
        check_eq({tag, "_ready_after"}, int'(a_ready), 1);
        check_eq({tag, "_busy_after"},  int'(a_busy),  0);
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_count_held"}, int'(a_cnt), 1);
    endtask

    task automatic apply_reset_a(input string tag);
        a_rst = 1'b1;
        #1;
        check_eq({tag, "_valid_in_reset"}, int'(a_valid), 0);
        @(posedge clk); #1;
        a_rst = 1'b0;
        check_eq({tag, "_ready"}, int'(a_ready), 1);
        check_eq({tag, "_busy"},  int'(a_busy),  0);
        check_eq({tag, "_valid"}, int'(a_valid), 0);
        check_eq({tag, "_count"}, int'(a_cnt),   0);
        $display("%s reset applied", tag);
    endtask

    task automatic run_u8a_sequence();
        bit found;
        run_first8("s1");

        // Reset while the search is running
        a_fa = 1'b0; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_eq("rst_search_busy_before", int'(a_busy), 1);
        apply_reset_a("rst_search");

        // Reset while the second solution is streaming (count already 1)
        found = 1'b0;
        a_fa = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        for (int c = 0; c < 20000 && !found; c++) begin
            @(posedge clk); #1;
            if (a_valid && a_cnt == 16'd1) found = 1'b1;
        end
        check_eq("rst_emit_reached", int'(found), 1);
        apply_reset_a("rst_emit");

        run_first8("s1_again");
    endtask

    // ---------------------------------------------------------------------
    // N=8 full enumeration on u8b
    // ---------------------------------------------------------------------
    task automatic run_all8();
        int exp_col[16] = '{0, 4, 7, 5, 2, 6, 1, 3,
                            0, 5, 7, 2, 6, 3, 1, 4};
        int beats = 0;
        bit got_done = 1'b0;
        b_fa = 1'b1; b_srdy = 1'b1; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int c = 0; c < 90000 && !got_done; c++) begin
            @(posedge clk); #1;
            if (b_valid) begin
                if (beats < 16) begin
                    check_eq("all8_col", int'(b_col), exp_col[beats]);
                    check_eq("all8_row", int'(b_row), beats % 8);
                end
                if (beats % 8 == 7)
                    $display("all8 solution %0d emitted (count before=%0d)", beats / 8 + 1, b_cnt);
                beats++;
            end
            if (b_done) got_done = 1'b1;
            if (b_na) check_eq("all8_no_answer", int'(b_na), 0);
        end
        check_eq("all8_done_seen", int'(got_done), 1);
        check_eq("all8_beats",     beats,          92 * 8);
        check_eq("all8_count",     int'(b_cnt),    92);
    endtask

    // ---------------------------------------------------------------------
    // N=4 enumeration with sol_ready toggling every cycle
    // ---------------------------------------------------------------------
    task automatic run_n4();
        int exp_col[8] = '{1, 3, 0, 2, 2, 0, 3, 1};
        int beats = 0;
        int stalls = 0;
        bit got_done = 1'b0;
        q_fa = 1'b1; q_srdy = 1'b0; q_start = 1'b1;
        @(posedge clk); #1;
        q_start = 1'b0;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            @(posedge clk); #1;
            // This value is what the next edge samples
            q_srdy = ~q_srdy;
            if (q_valid) begin
                if (beats < 8) begin
                    check_eq("n4_row",  int'(q_row),  beats % 4);
                    check_eq("n4_col",  int'(q_col),  exp_col[beats]);
                    check_eq("n4_last", int'(q_last), (beats % 4 == 3) ? 1 : 0);
                end else begin
                    check_eq("n4_beat_count", beats + 1, 8);
                end
                if (q_srdy) begin
                    $display("n4 beat row=%0d col=%0d last=%0d", q_row, q_col, q_last);
                    beats++;
                end else begin
                    stalls++;
                end
            end
            if (q_done) got_done = 1'b1;
        end
        check_eq("n4_done_seen", int'(got_done), 1);
        check_eq("n4_beats",     beats,          8);
        check_eq("n4_stalled",   int'(stalls > 0), 1);
        check_eq("n4_count",     int'(q_cnt),    2);
    endtask

    // ---------------------------------------------------------------------
    // N=3 and N=2: no solutions
    // ---------------------------------------------------------------------
    task automatic run_n32();
        int v3 = 0, na3 = 0, d3 = 0;
        int v2 = 0, na2 = 0, d2 = 0;
        t_fa = 1'b1; t_srdy = 1'b1; t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            v3  += int'(t3_valid); na3 += int'(t3_na); d3 += int'(t3_done);
            v2  += int'(t2_valid); na2 += int'(t2_na); d2 += int'(t2_done);
        end
        $display("n3 no_answer cycles=%0d valid cycles=%0d", na3, v3);
        $display("n2 no_answer cycles=%0d valid cycles=%0d", na2, v2);
        check_eq("n3_valid_cycles", v3,  0);
        check_eq("n3_na_cycles",    na3, 1);
        check_eq("n3_done_cycles",  d3,  0);
        check_eq("n3_count",        int'(t3_cnt),   0);
        check_eq("n3_ready",        int'(t3_ready), 1);
        check_eq("n2_valid_cycles", v2,  0);
        check_eq("n2_na_cycles",    na2, 1);
        check_eq("n2_done_cycles",  d2,  0);
        check_eq("n2_count",        int'(t2_cnt),   0);
        check_eq("n2_ready",        int'(t2_ready), 1);
    endtask

    // ---------------------------------------------------------------------
    // N=1
    // ---------------------------------------------------------------------
    task automatic run_n1();
        int beats = 0;
        bit got_done = 1'b0;
        o_fa = 1'b0; o_srdy = 1'b1; o_start = 1'b1;
        @(posedge clk); #1;
        o_start = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            @(posedge clk); #1;
            if (o_valid) begin
                check_eq("n1_row",  int'(o_row),  0);
                check_eq("n1_col",  int'(o_col),  0);
                check_eq("n1_last", int'(o_last), 1);
                $display("n1 beat row=%0d col=%0d last=%0d", o_row, o_col, o_last);
                beats++;
            end
            if (o_done) got_done = 1'b1;
        end
        check_eq("n1_done_seen", int'(got_done), 1);
        check_eq("n1_beats",     beats,          1);
        check_eq("n1_count",     int'(o_cnt),    1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0; m_rst = 1'b0;
        check_eq("reset_a_ready", int'(a_ready), 1);
        check_eq("reset_a_busy",  int'(a_busy),  0);
        check_eq("reset_a_valid", int'(a_valid), 0);
        check_eq("reset_a_count", int'(a_cnt),   0);
        check_eq("reset_b_ready", int'(b_ready), 1);
        check_eq("reset_q_ready", int'(q_ready), 1);
        check_eq("reset_q_count", int'(q_cnt),   0);
        check_eq("reset_o_busy",  int'(o_busy),  0);
        $display("reset released");

        fork
            run_all8();
            begin
                run_u8a_sequence();
                run_n4();
                run_n32();
                run_n1();
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
